// File: rtl/m_div_control_if.sv
// Request/response bundle between the M-unit issue logic and the divider control FSM.
interface m_div_control_if;
  logic        start;
  logic        is_signed;
  logic        want_rem;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (
    output start, is_signed, want_rem, rs1, rs2,
    input  busy, valid, result
  );

  modport slave (
    input  start, is_signed, want_rem, rs1, rs2,
    output busy, valid, result
  );
endinterface

// File: rtl/m_div_control.sv
// Control FSM for the 32-bit restoring divider: sequences the R/D/Z datapath
// registers for 32 iterations and applies the signed quotient/remainder fix-up.
module m_div_control (
  input  logic              clk,
  input  logic              resetn,
  m_div_control_if.slave    bus,
  input  logic [31:0]       R,
  input  logic [31:0]       Z,
  output logic [1:0]        mux_R,
  output logic [1:0]        mux_D,
  output logic [1:0]        mux_Z
);

  // Select encodings shared with the divider datapath.
  localparam logic [1:0] R_KEEP     = 2'd0;
  localparam logic [1:0] R_A        = 2'd1;
  localparam logic [1:0] R_A_NEG    = 2'd2;
  localparam logic [1:0] R_SUB_KEEP = 2'd3;
  localparam logic [1:0] D_KEEP     = 2'd0;
  localparam logic [1:0] D_B        = 2'd1;
  localparam logic [1:0] D_B_NEG    = 2'd2;
  localparam logic [1:0] D_SHR      = 2'd3;
  localparam logic [1:0] Z_KEEP     = 2'd0;
  localparam logic [1:0] Z_ZERO     = 2'd1;
  localparam logic [1:0] Z_SHL_ADD  = 2'd2;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e      state;
  state_e      state_n;
  logic [4:0]  count;
  logic        neg_q;
  logic        neg_r;
  logic        rem;
  logic        dz;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign q_fix = neg_q ? (32'd0 - Z) : Z;
  assign r_fix = neg_r ? (32'd0 - R) : R;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      count <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem   <= 1'b0;
      dz    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q <= bus.is_signed & (bus.rs1[31] ^ bus.rs2[31]);
            neg_r <= bus.is_signed & bus.rs1[31];
            rem   <= bus.want_rem;
            dz    <= (bus.rs2 == '0);
            count <= '0;
          end
        end
        ITER:    count <= count + 5'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    mux_R      = R_KEEP;
    mux_D      = D_KEEP;
    mux_Z      = Z_KEEP;
    bus.busy   = (state != IDLE);
    bus.valid  = 1'b0;
    bus.result = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.rs2 == '0) begin
            // Divide by zero: R carries raw rs1 so DONE can return it as the remainder.
            mux_R   = R_A;
            state_n = DONE;
          end else begin
            mux_R   = (bus.is_signed & bus.rs1[31]) ? R_A_NEG : R_A;
            mux_D   = (bus.is_signed & bus.rs2[31]) ? D_B_NEG : D_B;
            mux_Z   = Z_ZERO;
            state_n = ITER;
          end
        end
      end
      ITER: begin
        mux_R = R_SUB_KEEP;
        mux_D = D_SHR;
        mux_Z = Z_SHL_ADD;
        if (count == 5'd31) state_n = DONE;
      end
      DONE: begin
        bus.valid = 1'b1;
        state_n   = IDLE;
        if (dz) bus.result = rem ? R : '1;
        else    bus.result = rem ? r_fix : q_fix;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_div_control.sv
// Bench for m_div_control: behavioural restoring-divider datapath driven by the
// FSM selects, results checked against an arithmetic RISC-V division model.
module tb_m_div_control;

  localparam logic [1:0] R_KEEP     = 2'd0;
  localparam logic [1:0] R_A        = 2'd1;
  localparam logic [1:0] R_A_NEG    = 2'd2;
  localparam logic [1:0] R_SUB_KEEP = 2'd3;
  localparam logic [1:0] D_KEEP     = 2'd0;
  localparam logic [1:0] D_B        = 2'd1;
  localparam logic [1:0] D_B_NEG    = 2'd2;
  localparam logic [1:0] D_SHR      = 2'd3;
  localparam logic [1:0] Z_KEEP     = 2'd0;
  localparam logic [1:0] Z_ZERO     = 2'd1;
  localparam logic [1:0] Z_SHL_ADD  = 2'd2;

  logic        clk;
  logic        resetn;
  logic [31:0] R;
  logic [31:0] Z;
  logic [1:0]  mux_R;
  logic [1:0]  mux_D;
  logic [1:0]  mux_Z;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  m_div_control_if bus ();

  m_div_control dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .R      (R),
    .Z      (Z),
    .mux_R  (mux_R),
    .mux_D  (mux_D),
    .mux_Z  (mux_Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: D starts as divisor << 31 and shifts right; R subtracts when it can.
  logic [63:0] dp_r;
  logic [63:0] dp_d;
  logic [31:0] dp_z;
  logic [31:0] neg_a;
  logic [31:0] neg_b;
  logic        ge;

  assign neg_a = 32'd0 - bus.rs1;
  assign neg_b = 32'd0 - bus.rs2;
  assign ge    = (dp_r >= dp_d);
  assign R     = dp_r[31:0];
  assign Z     = dp_z;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dp_r <= '0;
      dp_d <= '0;
      dp_z <= '0;
    end else begin
      case (mux_R)
        R_A:        dp_r <= {32'd0, bus.rs1};
        R_A_NEG:    dp_r <= {32'd0, neg_a};
        R_SUB_KEEP: if (ge) dp_r <= dp_r - dp_d;
        default:    ;
      endcase
      case (mux_D)
        D_B:     dp_d <= {1'b0, bus.rs2, 31'd0};
        D_B_NEG: dp_d <= {1'b0, neg_b, 31'd0};
        D_SHR:   dp_d <= dp_d >> 1;
        default: ;
      endcase
      case (mux_Z)
        Z_ZERO:    dp_z <= '0;
        Z_SHL_ADD: dp_z <= {dp_z[30:0], ge};
        default:   ;
      endcase
    end
  end

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic w);
    int sa;
    int sb;
    if (b == 32'd0) return w ? a : 32'hFFFF_FFFF;
    if (!s) return w ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return w ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    return w ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation in the cycle after the previous one finished and waits for valid.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic w, input bit inject);
    int unsigned cyc;
    bit          got;
    logic [31:0] exp_res;
    logic [1:0]  exp_mr;
    logic [1:0]  exp_md;
    exp_res = ref_div(a, b, s, w);
    exp_mr  = (b == 32'd0) ? R_A : ((s & a[31]) ? R_A_NEG : R_A);
    exp_md  = (b == 32'd0) ? D_KEEP : ((s & b[31]) ? D_B_NEG : D_B);
    @(posedge clk);
    #1;
    check({tag, " idle valid"}, 32'(bus.valid), 32'd0);
    bus.start     = 1'b1;
    bus.rs1       = a;
    bus.rs2       = b;
    bus.is_signed = s;
    bus.want_rem  = w;
    #1;
    check({tag, " mux_R"}, 32'(mux_R), 32'(exp_mr));
    check({tag, " mux_D"}, 32'(mux_D), 32'(exp_md));
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.rs1       = $urandom;
    bus.rs2       = $urandom;
    bus.is_signed = $urandom_range(0, 1);
    bus.want_rem  = $urandom_range(0, 1);
    cyc = 1;
    got = 1'b0;
    while (cyc <= 40 && !got) begin
      bus.start = inject && (cyc == 10);
      if (bus.start) bus.rs2 = 32'd0;
      @(negedge clk);
      if (bus.valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    check({tag, " latency"}, got ? 32'(cyc) : 32'd0, (b == 32'd0) ? 32'd1 : 32'd33);
    check({tag, " result"}, bus.result, exp_res);
  endtask

  initial begin
    resetn        = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.want_rem  = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    #3;
    check("rst busy",   32'(bus.busy),  32'd0);
    check("rst valid",  32'(bus.valid), 32'd0);
    check("rst result", bus.result,     32'd0);
    check("rst mux_R",  32'(mux_R),     32'(R_KEEP));
    check("rst mux_D",  32'(mux_D),     32'(D_KEEP));
    check("rst mux_Z",  32'(mux_Z),     32'(Z_KEEP));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    do_op("divu 100/7", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    do_op("remu 100/7", 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    do_op("div -7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    do_op("rem -7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
    do_op("div 7/-2",   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    do_op("rem 7/-2",   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    do_op("div ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("rem ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op("div 5/0",    32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    do_op("rem -5/0",   32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 1'b0);
    do_op("divu ign",   32'd1000, 32'd3, 1'b0, 1'b0, 1'b1);

    // Abort mid-iteration with reset, then confirm no stray pulse and a clean restart.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.rs1   = 32'd12345;
    bus.rs2   = 32'd17;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort busy",  32'(bus.busy),  32'd0);
    check("abort valid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid) check("abort stray valid", 32'(bus.valid), 32'd0);
    end
    check("abort idle", 32'(bus.busy), 32'd0);
    do_op("after abort", 32'd12345, 32'd17, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      do_op("random", pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
